// File: rtl/fir_out_pkg.sv
// fir_out_pkg: shared widths, saturation limits and round/shift/saturate helpers
package fir_out_pkg;
  localparam int DEF_IN_W = 32;
  localparam int DEF_OUT_W = 16;
  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;
  typedef struct packed {
    logic ovf;
    logic signed [15:0] data;
  } sat_t;
  function automatic logic signed [32:0] round_shift(input logic signed [31:0] r, input logic [4:0] sh);
    logic signed [32:0] x;
    x = {r[31], r};
    return (x + ((sh == 5'd0) ? 33'sd0 : (33'sd1 <<< (sh - 5'd1)))) >>> sh;
  endfunction
  function automatic sat_t saturate(input logic signed [32:0] v);
    return (v > 33'sd32767) ? '{1'b1, SAT_MAX} : (v < -33'sd32768) ? '{1'b1, SAT_MIN} : '{1'b0, v[15:0]};
  endfunction
endpackage

// File: rtl/fir_output_stage_if.sv
// fir_output_stage_if: valid/ready output sample stream
interface fir_output_stage_if #(parameter int OUT_W = 16);
  logic out_valid;
  logic out_ready;
  logic signed [OUT_W-1:0] out_data;
  modport master(output out_valid, output out_data, input out_ready);
  modport slave(input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fir_output_stage_out_fifo.sv
// out_fifo: single-clock synchronous FIFO with head-of-queue output
module out_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rd_ptr];
  // storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fir_output_stage.sv
// fir_output_stage: captures MAC results, rounds/saturates to 16 bits and streams them out
module fir_output_stage
  import fir_out_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic done,
  input  logic signed [IN_W-1:0] result,
  input  logic [4:0] shift,
  input  logic clr_flags,
  fir_output_stage_if.master o,
  output logic overflow,
  output logic drop,
  output logic [15:0] count
);
  logic done_q, s1_v, s2_v, full, empty, fire;
  logic signed [IN_W:0] s1_val;
  logic signed [OUT_W-1:0] s2_data, head;
  sat_t sat;
  assign sat = saturate(s1_val);
  assign fire = o.out_valid & o.out_ready;
  assign o.out_valid = ~empty;
  assign o.out_data = empty ? '0 : head;
  // edge detect on done and valid tracking through both stages
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      done_q <= done;
      s1_v <= done & ~done_q;
      s2_v <= s1_v;
    end
  end
  // datapath registers: round/shift on capture, saturate one stage later
  always_ff @(posedge clk) begin
    s1_val <= round_shift(result, shift);
    s2_data <= sat.data;
  end
  // sticky flags where a set event beats a simultaneous clear; accepted-sample counter
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop <= 1'b0;
      count <= '0;
    end else begin
      overflow <= (s1_v & sat.ovf) | (overflow & ~clr_flags);
      drop <= (s2_v & full & ~fire) | (drop & ~clr_flags);
      count <= count + 16'(fire);
    end
  end
  out_fifo #(.DEPTH(DEPTH), .W(OUT_W)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(s2_v),
    .pop(fire),
    .din(s2_data),
    .head(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: doc/fir_output_stage.md
Name: fir_output_stage

Overview:
- Downstream consumer of the FIR datapath.
- Captures the 32-bit signed MAC `result` each time `done` rises, then rounds, scales and saturates it to a 16-bit output sample.
- Buffers samples in a small FIFO and presents them on a valid/ready stream to the output interface.
- Provides sticky overflow and drop flags plus an emitted-sample counter for host/debug visibility.

Parameters:
- DEPTH, 4: output FIFO entries; power of two, ≥2.
- IN_W, 32: width of the MAC result.
- OUT_W, 16: width of the output sample.

Ports:
- clk  in  1  single clock for the whole block (the datapath read/MAC clock domain).
- reset  in  1  synchronous, active-high reset.
- done  in  1  MAC-complete indicator from the datapath; a level, may stay high.
- result  in  IN_W  signed MAC accumulation; valid whenever done=1.
- shift  in  5  right-shift amount 0..31; sampled on the capture cycle.
- clr_flags  in  1  one-cycle pulse that clears overflow and drop.
- out_ready  in  1  downstream accepts the sample.
- out_valid  out  1  head sample available.
- out_data  out  OUT_W  signed head sample; 0 when out_valid=0.
- overflow  out  1  sticky; set when any captured sample saturated.
- drop  out  1  sticky; set when a sample was lost because the FIFO was full.
- count  out  16  number of samples accepted downstream (out_valid&out_ready); wraps 0xFFFF→0.

Behaviour:
- Reset (clk edge with reset=1):
  - Clears done_q, stage-1 valid, stage-2 valid, FIFO pointers and occupancy.
  - Clears overflow, drop and count.
  - Outputs: out_valid=0, out_data=0.
  - In-flight samples are discarded; reset has priority over every other event.
- Capture: capture = done & ~done_q, where done_q is the registered done. Exactly one capture per rising edge of done, however long done stays high.
- Stage 1, at the capture edge:
  - Sign-extend result to 33 bits.
  - If shift>0, add 2^(shift-1) (round half up).
  - Arithmetic right shift by shift; register the value and valid.
- Stage 2, next edge:
  - Saturate to [-32768, 32767].
  - Set overflow if clipping occurred.
  - Push into FIFO.
- Latency: a capture at edge E0 makes the sample visible at the FIFO head after edge E0+2 (out_valid=1 from that cycle if the FIFO was empty). Pipeline throughput is one sample per cycle.
- FIFO:
  - Pop on out_valid&out_ready.
  - Push when full with no pop in the same cycle: the sample is discarded and drop is set.
  - Push and pop in the same cycle when full: both occur and drop is not set.
  - Push and pop in the same cycle when empty are impossible, since out_valid=0.
  - Strict in-order delivery; pointers wrap modulo DEPTH.
- Handshake:
  - out_data/out_valid are stable while out_valid=1 and out_ready=0.
  - out_ready is allowed to be high while out_valid=0, and has no effect then.
- Flags:
  - clr_flags clears overflow and drop.
  - If a set event occurs in the same cycle as clr_flags, set wins.
- count increments by 1 per accepted sample.

Decomposition:
- Package fir_out_pkg holds:
  - IN_W/OUT_W defaults.
  - SAT_MAX = 16'sh7FFF and SAT_MIN = 16'sh8000.
  - The round/shift/saturate function shared with any future output formats.
- One sub-module, out_fifo: a single-clock synchronous FIFO with parameterised DEPTH/width and push/pop/full/empty/head ports.
- Capture logic and the two-stage pipeline stay in fir_output_stage.

Test Plan:
- Reset: hold reset 2 cycles with done=1 → out_valid=0, out_data=0, count=0, overflow=0, drop=0; no capture while reset is held.
- Rounding: with out_ready=1, drive result=1000, shift=2 with a one-cycle done pulse → out_valid high 2 cycles after the capture edge with out_data=250. Then:
  - result=1002, shift=2 → out_data=251.
  - result=-6, shift=2 → out_data=16'hFFFF (-1).
  - After these three, count=3.
- Saturation: result=32'h0010_0000, shift=0 → out_data=16'h7FFF, overflow=1. Then result=-200000, shift=0 → out_data=16'h8000. Then pulse clr_flags → overflow=0.
- Level done: hold done high 10 cycles with result=5, shift=0 → exactly one sample (5) emitted, count=1.
- Full/drop: out_ready=0, five done pulses spaced 2 cycles with result=1..5, shift=0 → after the 5th, drop=1. Then raise out_ready → samples 1,2,3,4 in order, then out_valid=0 and count=4.
- Reset mid-operation: done pulse with result=7, then reset asserted on the following edge → no sample ever appears and count stays 0.
